adc_read_stream_source: RTL and testbench
=========================================

Name: adc_read_stream_source

Overview:
- User-side source that feeds a host read stream of the PCIe core: 32-bit data, empty, eof and rden, gated by open.
- Packs 8-bit ADC samples into 32-bit words and buffers them in a small standard (non-FWFT) FIFO.
- Ends each capture with eof after a fixed word count.
- One instance per ADC channel (ch1, ch2), all on the bus clock domain.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in 32-bit words (16 words).
- CAPTURE_WORDS, 1024, words per capture, counting both stored and dropped words; range 1..65535.

Ports:
- bus_clk  input  1  system/bus clock; all logic rising-edge.
- trn_reset_n  input  1  asynchronous active-low reset.
- sample_valid  input  1  one sample present this cycle.
- sample_data  input  8  ADC sample.
- user_r_read_open  input  1  host has stream open.
- user_r_read_rden  input  1  host read strobe.
- user_r_read_data  output  32  read word, valid the cycle after an accepted rden.
- user_r_read_empty  output  1  FIFO empty.
- user_r_read_eof  output  1  end of capture.
- overflow  output  1  sticky: at least one word dropped this capture.

Behaviour:
- Reset (asynchronous, trn_reset_n low):
  - state=IDLE; FIFO pointers, packer and counters cleared.
  - user_r_read_data=0, user_r_read_empty=1, user_r_read_eof=0, overflow=0.
- State machine (IDLE, CAPTURE, DONE):
  - IDLE->CAPTURE on the rising edge of open (open=1 registered, previous=0). The same edge clears overflow, the packer, the word counter and the FIFO.
  - CAPTURE->DONE when the packed-word counter reaches CAPTURE_WORDS.
  - From any state, open=0 -> IDLE on the next edge; FIFO flushed and packer discarded.
  - DONE holds until open falls.
- Packing:
  - Samples accepted only in CAPTURE with sample_valid=1.
  - First sample goes to bits [7:0], second [15:8], third [23:16], fourth [31:24].
  - On the fourth sample the word is pushed and the lane index returns to 0.
  - Samples arriving in IDLE or DONE are ignored.
  - A partial word at CAPTURE exit or close is discarded.
- Word counter:
  - 16-bit; increments on every completed word, stored or dropped.
  - DONE is entered the cycle after the CAPTURE_WORDS-th word completes.
- FIFO write:
  - Uses full computed from the count at the start of the cycle.
  - If full, the word is dropped and overflow is set, even when a read occurs in the same cycle.
- FIFO read:
  - rden with empty=0 pops; user_r_read_data updates on that edge, i.e. data valid one cycle after rden.
  - rden with empty=1 is ignored: no pointer change, data holds its last value.
- Flags:
  - Simultaneous push and pop leaves the count unchanged.
  - empty is registered and reflects the count after the edge; it deasserts the cycle after the first push.
- eof:
  - user_r_read_eof=1 only when state=DONE and empty=1; registered.
  - Drops with open or reset.
- Pointers:
  - DEPTH_LOG2+1-bit, so full vs empty is unambiguous.
  - Wrap-around at 2^DEPTH_LOG2 is transparent.
- Reset mid-capture: everything clears immediately; a subsequent open rising edge starts a fresh capture.

Test Plan:
- Reset then open=1; feed samples 0x01..0x08 contiguously; CAPTURE_WORDS=2 -> words 0x04030201, 0x08070605 read in order; eof=1 after the second pop with empty=1.
- CAPTURE_WORDS=20, DEPTH_LOG2=4, no rden during 80 samples -> 16 words stored, 4 dropped, overflow=1, state DONE. Draining 16 words then gives empty=1, eof=1.
- rden pulsed with empty=1 -> no data change, no pointer movement. Next push then pop returns the correct word.
- Sustained push+pop at full (count 16) -> incoming word dropped, overflow=1, count stays 15 after the pop.
- open falls mid-capture after 6 samples -> FIFO flushed, empty=1, eof=0. Reopen and feed 4 samples 0xAA,0xBB,0xCC,0xDD -> first word 0xDDCCBBAA.
- trn_reset_n asserted low mid-capture with 10 words buffered -> outputs immediately at reset values. Reopen -> capture restarts with overflow=0.

Source files
------------

// File: rtl/adc_read_stream_source_if.sv
// Host read-stream bundle between the PCIe core (slave) and a user-side source (master).
interface adc_read_stream_source_if;
    logic        user_r_read_open;
    logic        user_r_read_rden;
    logic [31:0] user_r_read_data;
    logic        user_r_read_empty;
    logic        user_r_read_eof;

    modport master (
        input  user_r_read_open,
        input  user_r_read_rden,
        output user_r_read_data,
        output user_r_read_empty,
        output user_r_read_eof
    );

    modport slave (
        output user_r_read_open,
        output user_r_read_rden,
        input  user_r_read_data,
        input  user_r_read_empty,
        input  user_r_read_eof
    );
endinterface

// File: rtl/adc_read_stream_source.sv
// Packs 8-bit ADC samples into 32-bit words, buffers them in a standard FIFO
// and serves them on a host read stream, ending each capture with eof.
module adc_read_stream_source #(
    parameter int unsigned DEPTH_LOG2    = 4,
    parameter int unsigned CAPTURE_WORDS = 1024
) (
    input  logic                            bus_clk,
    input  logic                            trn_reset_n,
    input  logic                            sample_valid,
    input  logic [7:0]                      sample_data,
    adc_read_stream_source_if.master        rd,
    output logic                            overflow
);
    localparam int unsigned          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [15:0]          CAP_CNT   = 16'(CAPTURE_WORDS);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t              state, state_n;
    logic                open_prev;
    logic [1:0]          lane;
    logic [23:0]         pack;
    logic [15:0]         word_cnt;
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count, count_n;
    logic [31:0]         mem [DEPTH];
    logic [31:0]         data_q;
    logic                empty_q, eof_q;

    logic open, open_rise, flush, full, capture_end, take, word_done, push, drop, pop;
    logic [31:0] word;

    assign open        = rd.user_r_read_open;
    assign open_rise   = open && !open_prev;
    // Both a close and a fresh open throw away everything buffered for the old capture.
    assign flush       = !open || open_rise;
    assign count       = wr_ptr - rd_ptr;
    assign full        = (count == DEPTH_CNT);
    assign capture_end = (word_cnt == CAP_CNT);
    assign take        = (state == CAPTURE) && !capture_end && sample_valid && !flush;
    assign word_done   = take && (lane == 2'd3);
    assign push        = word_done && !full;
    assign drop        = word_done && full;
    assign pop         = rd.user_r_read_rden && !empty_q && !flush;
    assign word        = {sample_data, pack};

    always_comb begin
        wr_ptr_n = flush ? '0 : wr_ptr + (DEPTH_LOG2 + 1)'(push);
        rd_ptr_n = flush ? '0 : rd_ptr + (DEPTH_LOG2 + 1)'(pop);
        count_n  = wr_ptr_n - rd_ptr_n;
    end

    always_comb begin
        state_n = state;
        if (!open) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (open_rise) state_n = CAPTURE;
                CAPTURE: if (capture_end) state_n = DONE;
                DONE:    state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge bus_clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= word;
    end

    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state     <= IDLE;
            open_prev <= 1'b0;
            lane      <= '0;
            pack      <= '0;
            word_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            data_q    <= '0;
            empty_q   <= 1'b1;
            eof_q     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            open_prev <= open;
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            empty_q   <= (count_n == '0);
            eof_q     <= (state_n == DONE) && (count_n == '0);

            if (flush) begin
                lane     <= '0;
                pack     <= '0;
                word_cnt <= '0;
            end else if (take) begin
                lane <= lane + 2'd1;
                unique case (lane)
                    2'd0:    pack[7:0]   <= sample_data;
                    2'd1:    pack[15:8]  <= sample_data;
                    2'd2:    pack[23:16] <= sample_data;
                    default: pack        <= '0;
                endcase
                if (word_done) word_cnt <= word_cnt + 16'd1;
            end

            // Overflow survives a close so the host can still inspect it; only a new capture clears it.
            if (open_rise)  overflow <= 1'b0;
            else if (drop)  overflow <= 1'b1;

            if (pop) data_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        end
    end

    assign rd.user_r_read_data  = data_q;
    assign rd.user_r_read_empty = empty_q;
    assign rd.user_r_read_eof   = eof_q;
endmodule

// File: tb/tb_adc_read_stream_source.sv
// Directed bench: two instances (2-word and 20-word captures) share one stimulus stream.
module tb_adc_read_stream_source;
    logic       clk = 1'b0;
    logic       rst_n, sv, open, rden;
    logic [7:0] sd;
    logic       ovf_a, ovf_b;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    adc_read_stream_source_if ifa ();
    adc_read_stream_source_if ifb ();
    assign ifa.user_r_read_open = open;
    assign ifa.user_r_read_rden = rden;
    assign ifb.user_r_read_open = open;
    assign ifb.user_r_read_rden = rden;

    adc_read_stream_source #(.DEPTH_LOG2(4), .CAPTURE_WORDS(2)) dut_a (
        .bus_clk(clk), .trn_reset_n(rst_n), .sample_valid(sv), .sample_data(sd),
        .rd(ifa), .overflow(ovf_a));

    adc_read_stream_source #(.DEPTH_LOG2(4), .CAPTURE_WORDS(20)) dut_b (
        .bus_clk(clk), .trn_reset_n(rst_n), .sample_valid(sv), .sample_data(sd),
        .rd(ifb), .overflow(ovf_b));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        sv = 1'b1;
        sd = b;
        tick();
        sv = 1'b0;
    endtask

    task automatic feed(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) put(first + 8'(i));
    endtask

    task automatic pops(input int n);
        rden = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rden = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    initial begin
        rst_n = 1'b0; sv = 1'b0; sd = '0; open = 1'b0; rden = 1'b0;
        tick(); tick();
        check_eq("rst_data", ifb.user_r_read_data, 32'h0);
        check_eq("rst_empty", 32'(ifb.user_r_read_empty), 32'd1);
        check_eq("rst_eof", 32'(ifb.user_r_read_eof), 32'd0);
        check_eq("rst_ovf", 32'(ovf_b), 32'd0);
        rst_n = 1'b1;
        tick();

        // Two-word capture on dut_a
        open = 1'b1; tick();
        feed(8, 8'h01);
        tick();
        check_eq("a_empty_before_pop", 32'(ifa.user_r_read_empty), 32'd0);
        check_eq("a_eof_before_pop", 32'(ifa.user_r_read_eof), 32'd0);
        rden = 1'b1; tick();
        check_eq("a_word0", ifa.user_r_read_data, 32'h04030201);
        check_eq("a_eof_mid", 32'(ifa.user_r_read_eof), 32'd0);
        tick(); rden = 1'b0;
        check_eq("a_word1", ifa.user_r_read_data, 32'h08070605);
        check_eq("a_empty_end", 32'(ifa.user_r_read_empty), 32'd1);
        check_eq("a_eof_end", 32'(ifa.user_r_read_eof), 32'd1);
        open = 1'b0; tick();
        check_eq("a_eof_close", 32'(ifa.user_r_read_eof), 32'd0);
        check_eq("b_empty_close", 32'(ifb.user_r_read_empty), 32'd1);

        // Overflow: 20 words without reads into a 16-word FIFO
        open = 1'b1; tick();
        feed(80, 8'h00);
        tick();
        check_eq("ovf_set", 32'(ovf_b), 32'd1);
        check_eq("ovf_empty", 32'(ifb.user_r_read_empty), 32'd0);
        check_eq("ovf_eof_nonempty", 32'(ifb.user_r_read_eof), 32'd0);
        rden = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            check_eq($sformatf("ovf_word%0d", k), ifb.user_r_read_data, word_of(8'(4 * k)));
        end
        rden = 1'b0;
        check_eq("ovf_drained_empty", 32'(ifb.user_r_read_empty), 32'd1);
        check_eq("ovf_drained_eof", 32'(ifb.user_r_read_eof), 32'd1);
        feed(4, 8'h90);
        tick();
        check_eq("done_ignores_samples", 32'(ifb.user_r_read_empty), 32'd1);
        open = 1'b0; tick();
        check_eq("ovf_sticky_after_close", 32'(ovf_b), 32'd1);
        open = 1'b1; tick();
        check_eq("ovf_cleared_on_open", 32'(ovf_b), 32'd0);

        // Read strobe while empty
        pops(1);
        check_eq("rden_empty_hold", ifb.user_r_read_data, 32'h3F3E3D3C);
        check_eq("rden_empty_still", 32'(ifb.user_r_read_empty), 32'd1);
        feed(4, 8'h11);
        check_eq("first_push_empty", 32'(ifb.user_r_read_empty), 32'd0);
        pops(1);
        check_eq("push_pop_word", ifb.user_r_read_data, 32'h14131211);
        check_eq("push_pop_empty", 32'(ifb.user_r_read_empty), 32'd1);

        // Push and pop together while full
        feed(64, 8'h20);
        feed(3, 8'h60);
        rden = 1'b1;
        put(8'h63);
        rden = 1'b0;
        check_eq("full_pp_word", ifb.user_r_read_data, word_of(8'h20));
        check_eq("full_pp_ovf", 32'(ovf_b), 32'd1);
        pops(14);
        check_eq("full_pp_one_left", 32'(ifb.user_r_read_empty), 32'd0);
        check_eq("full_pp_word14", ifb.user_r_read_data, word_of(8'h58));
        pops(1);
        check_eq("full_pp_last", ifb.user_r_read_data, word_of(8'h5C));
        check_eq("full_pp_empty", 32'(ifb.user_r_read_empty), 32'd1);
        check_eq("full_pp_eof", 32'(ifb.user_r_read_eof), 32'd0);

        // Close mid-capture discards FIFO and partial word
        open = 1'b0; tick();
        open = 1'b1; tick();
        feed(6, 8'h70);
        check_eq("mid_close_pre", 32'(ifb.user_r_read_empty), 32'd0);
        open = 1'b0; tick();
        check_eq("mid_close_empty", 32'(ifb.user_r_read_empty), 32'd1);
        check_eq("mid_close_eof", 32'(ifb.user_r_read_eof), 32'd0);
        open = 1'b1; tick();
        put(8'hAA); put(8'hBB); put(8'hCC); put(8'hDD);
        check_eq("reopen_nonempty", 32'(ifb.user_r_read_empty), 32'd0);
        pops(1);
        check_eq("reopen_word", ifb.user_r_read_data, 32'hDDCCBBAA);

        // Asynchronous reset with 10 words buffered and overflow set
        feed(68, 8'h00);
        check_eq("pre_rst_ovf", 32'(ovf_b), 32'd1);
        pops(6);
        check_eq("pre_rst_word", ifb.user_r_read_data, word_of(8'h14));
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_data", ifb.user_r_read_data, 32'h0);
        check_eq("async_rst_empty", 32'(ifb.user_r_read_empty), 32'd1);
        check_eq("async_rst_eof", 32'(ifb.user_r_read_eof), 32'd0);
        check_eq("async_rst_ovf", 32'(ovf_b), 32'd0);
        open = 1'b0; tick();
        rst_n = 1'b1; tick();
        open = 1'b1; tick();
        feed(4, 8'h01);
        pops(1);
        check_eq("post_rst_word", ifb.user_r_read_data, 32'h04030201);
        check_eq("post_rst_empty", 32'(ifb.user_r_read_empty), 32'd1);
        check_eq("post_rst_ovf", 32'(ovf_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
